// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver (8N1) feeding a show-ahead byte FIFO, with
// one-cycle frame_err / overrun / parity_err pulses. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t          state, state_next;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            presc_clear;
  logic            rx_meta, rx_s;
  logic [3:0]      tick_cnt, tick_cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            push;
  logic            frame_err_c;
  logic            parity_err_c;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_next;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Oversample prescaler, realigned to the start edge so bit centres stay put.
  always_ff @(posedge clk) begin
    if (reset || presc_clear || tick)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
`ifdef UART_RX_PARITY_EN
    par_next      = par_bit;
`endif
    push          = 1'b0;
    frame_err_c   = 1'b0;
    parity_err_c  = 1'b0;
    presc_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next    = START;
          tick_cnt_next = '0;
          presc_clear   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          tick_cnt_next = tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) begin
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next    = DATA;
              tick_cnt_next = '0;
              bit_idx_next  = '0;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_next = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift_next[bit_idx] = rx_s;
            bit_idx_next        = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tick_cnt_next = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            par_next   = rx_s;
            state_next = STOP;
          end
        end
      end
`endif
      // A bad stop bit wins over a parity mismatch; only clean frames are pushed.
      STOP: begin
        if (tick) begin
          tick_cnt_next = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (rx_s) begin
              state_next = IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^shift_reg) ^ par_bit)
                parity_err_c = 1'b1;
              else
                push = 1'b1;
`else
              push = 1'b1;
`endif
            end else begin
              state_next  = WAIT_IDLE;
              frame_err_c = 1'b1;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_err  = frame_err_c;
  assign parity_err = parity_err_c;

  // A full FIFO still takes the byte if the head leaves on the same edge.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign wr_en    = push && (!full || pop);
  assign overrun  = push && full && !pop;
  assign rx_count = count;
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front-end that feeds the rx_valid/rx_ready/rx_data side of the AHB UART slave. It oversamples the asynchronous rx pin 16x, deframes 8N1 characters (LSB first) and buffers complete bytes in a small show-ahead FIFO. It also reports framing and overrun events as single-cycle pulses.

Parameters:
CLOCK_FREQ, 50000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
rx  input  1  asynchronous serial input, idle high
rx_data  output  8  byte at FIFO head, valid when rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer pops the head byte when rx_valid=1
rx_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held
frame_err  output  1  one-cycle pulse on bad stop bit
overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when UART_RX_PARITY_EN is undefined

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - rx_valid=0, rx_count=0, frame_err=0, overrun=0, parity_err=0.
  - rx_data=0 (head of the empty FIFO reads as 0).
  - FSM in IDLE; both rx synchroniser flops set to 1.
- Reset mid-frame abandons the frame and empties the FIFO.
- Oversample tick:
  - DIV = CLOCK_FREQ/(BAUD_RATE*16), integer truncation, minimum 1. The default value is 27.
  - A prescaler counts 0..DIV-1 and asserts tick for one cycle on wrap.
  - The prescaler restarts at 0 on every IDLE->START transition.
- rx_s = rx passed through 2 flops. All FSM decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A 4-bit tick counter and a 3-bit bit index are used.
  - IDLE: rx_s=0 -> START, tick counter cleared.
  - START: on the 8th tick (mid start bit), sample rx_s.
    - 1 -> IDLE (glitch, no event).
    - 0 -> DATA, tick counter cleared, bit index 0.
  - DATA: every 16th tick, shift rx_s into bit [index] (LSB first).
    - After index 7 -> STOP (or PARITY when enabled).
  - STOP: on the 16th tick, sample.
    - 1 -> push the byte, then IDLE.
    - 0 -> frame_err pulse, byte discarded, then WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then IDLE. This covers line breaks.
- Push and frame_err are asserted in the same cycle as the stop sample.
- Latency: rx_valid rises exactly 1 cycle after the push cycle (registered FIFO write).
- FIFO:
  - Show-ahead: rx_data always equals the oldest entry.
  - Pop occurs on the clk edge when rx_valid && rx_ready.
  - rx_ready while empty is ignored.
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun pulses for 1 cycle; FIFO contents are unchanged.
  - Simultaneous push and pop leaves rx_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; rx_count saturates at 0..FIFO_DEPTH by construction.
- Error pulses never coincide with a push of the same frame.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1: a PARITY state between DATA and STOP samples a parity bit on its 16th tick.
  - If the XOR of the 8 data bits and the parity bit is 1, parity_err pulses during the stop-sample cycle. The byte is not pushed, and the FSM proceeds through STOP normally.
  - A stop bit error takes precedence: only frame_err pulses.
- Undefined:
  - 8N1 framing; parity_err is tied to 0; the PARITY state does not exist.

Test Plan:
- CLOCK_FREQ=1600000, BAUD_RATE=100000 (DIV=1, 16 clk/bit); send 0xA5 8N1, rx_ready=0 -> rx_valid=1 about 160 clk after the start edge, rx_data=0xA5, rx_count=1, no error pulses.
- Send 0x01, 0x02, 0x03, 0x04, 0x55 with no pops (FIFO_DEPTH=4) -> rx_count=4, overrun pulses once at the 5th stop sample; pops return 0x01..0x04 in order, then rx_valid=0.
- Send 0x3C with the stop bit driven 0, then hold rx low for 40 bit times -> frame_err pulses once, rx_count=0; after rx returns high, 0x7E is received correctly.
- 4-clk low glitch on idle rx -> FSM returns to IDLE, no push, no pulses.
- FIFO full with rx_ready=1 held in the stop-sample cycle of 0x99 -> head popped and 0x99 accepted, rx_count stays 4, no overrun.
- Assert reset mid-DATA with 2 bytes buffered -> next cycle rx_valid=0, rx_count=0; a subsequent 0xC3 is received cleanly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no push; 0x07 with parity bit 1 -> push 0x07.
